// File: rtl/led_status_if.sv
// led_status_if: input/output bundle for the self-destruct LED output stage
// Signals:
//   combat    - debounced in-combat level (master -> slave)
//   armed     - 2-of-3 danger vote (master -> slave)
//   cnt_in    - 4-bit countdown value (master -> slave)
//   leds      - 4-bit LED drive, 1 = lit (slave -> master)
//   detonated - high while in DEAD (slave -> master)
//   state_out - IDLE=00, ARMED=01, WARN=10, DEAD=11 (slave -> master)
interface led_status_if;
    logic       combat;
    logic       armed;
    logic [3:0] cnt_in;
    logic [3:0] leds;
    logic       detonated;
    logic [1:0] state_out;
    modport master (output combat, armed, cnt_in, input leds, detonated, state_out);
    modport slave (input combat, armed, cnt_in, output leds, detonated, state_out);
endinterface

// File: rtl/led_status_driver.sv
// led_status_driver: drives the 4 board LEDs for idle/armed/warning/detonated states
// Ports:
//   clk   - main 12 MHz clock
//   reset - synchronous, active-high reset
//   bus   - led_status_if.slave: combat, armed, cnt_in in; leds, detonated, state_out out
module led_status_driver #(
    parameter int TICK_DIV   = 120000,
    parameter int BLINK_HALF = 25,
    parameter int WARN_LEVEL = 8,
    parameter int DEAD_LEVEL = 11
) (
    input logic         clk,
    input logic         reset,
    led_status_if.slave bus
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int BW = $clog2(BLINK_HALF + 1);
    typedef enum logic [1:0] {IDLE = 2'b00, ARMED = 2'b01, WARN = 2'b10, DEAD = 2'b11} state_t;
    state_t        state, nxt;
    logic [PW-1:0] pre;
    logic [BW-1:0] bcnt, bcnt_nxt;
    logic          phase, phase_nxt, tick, wrap, enter_warn;
    logic [3:0]    leds_nxt;
    assign tick = pre == PW'(TICK_DIV - 1);
    assign wrap = tick && bcnt == BW'(BLINK_HALF - 1);
    always_comb begin
        nxt = !bus.combat                         ? IDLE  :
              state == DEAD                       ? DEAD  :
              bus.cnt_in >= 4'(DEAD_LEVEL)        ? DEAD  :
              bus.cnt_in >= 4'(WARN_LEVEL)        ? WARN  :
              (bus.cnt_in != 4'd0 || bus.armed)   ? ARMED : IDLE;
    end
    // Entering WARN restarts the blink so the first half-period is lit; it overrides a coincident tick
    assign enter_warn = nxt == WARN && state != WARN;
    assign bcnt_nxt   = (enter_warn || wrap) ? '0 : tick ? bcnt + BW'(1) : bcnt;
    assign phase_nxt  = enter_warn ? 1'b1 : wrap ? ~phase : phase;
    // LEDs follow the next state and current inputs so they land together with state_out
    always_comb begin
        leds_nxt = nxt == IDLE  ? {3'b000, bus.combat & phase_nxt} :
                   nxt == ARMED ? bus.cnt_in :
                   nxt == WARN  ? (phase_nxt ? bus.cnt_in : 4'b0000) : 4'b1111;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pre      <= '0;
            bcnt     <= '0;
            phase    <= 1'b0;
            bus.leds <= 4'b0000;
        end else begin
            state    <= nxt;
            pre      <= tick ? '0 : pre + PW'(1);
            bcnt     <= bcnt_nxt;
            phase    <= phase_nxt;
            bus.leds <= leds_nxt;
        end
    end
    assign bus.detonated = state == DEAD;
    assign bus.state_out = state;
endmodule

// File: tb/tb_led_status_driver.sv
// tb_led_status_driver: table, corner-case and randomized checks of led_status_driver
module tb_led_status_driver;
    localparam int TD = 4;
    localparam int BH = 2;
    localparam int WL = 8;
    localparam int DL = 11;

    typedef struct packed {
        logic       r;
        logic       c;
        logic       a;
        logic [3:0] n;
        logic [1:0] st;
        logic [3:0] l;
        logic       d;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    led_status_if bus ();

    led_status_driver #(
        .TICK_DIV(TD),
        .BLINK_HALF(BH),
        .WARN_LEVEL(WL),
        .DEAD_LEVEL(DL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Reference model: clocks since reset give the prescaler phase; blink phase is the
    // anchor phase flipped once per BH ticks counted since the last reset or WARN entry.
    int         m_cyc = 0;
    int         m_ticks = 0;
    int         m_aph = 0;
    int         m_state = 0;
    logic [3:0] m_leds = 4'd0;

    task automatic model_edge();
        bit   tk;
        int   ns;
        logic ph;
        tk = (m_cyc % TD) == TD - 1;
        if (reset) begin
            m_cyc = 0;
            m_ticks = 0;
            m_aph = 0;
            m_state = 0;
        end else begin
            if (!bus.combat) ns = 0;
            else if (m_state == 3) ns = 3;
            else if (int'(bus.cnt_in) >= DL) ns = 3;
            else if (int'(bus.cnt_in) >= WL) ns = 2;
            else if (bus.cnt_in != 0 || bus.armed) ns = 1;
            else ns = 0;
            if (ns == 2 && m_state != 2) begin
                m_ticks = 0;
                m_aph = 1;
            end else if (tk) begin
                m_ticks++;
            end
            m_state = ns;
            m_cyc++;
        end
        ph = (m_aph[0] ^ (((m_ticks / BH) % 2) == 1));
        if (reset) m_leds = 4'd0;
        else if (m_state == 0) m_leds = {3'b000, bus.combat & ph};
        else if (m_state == 1) m_leds = bus.cnt_in;
        else if (m_state == 2) m_leds = ph ? bus.cnt_in : 4'd0;
        else m_leds = 4'hf;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic c, input logic a, input logic [3:0] n);
        reset = r;
        bus.combat = c;
        bus.armed = a;
        bus.cnt_in = n;
        @(posedge clk);
        model_edge();
        #1;
        check("model_state", int'(bus.state_out), m_state);
        check("model_leds", int'(bus.leds), int'(m_leds));
        check("model_det", int'(bus.detonated), int'(m_state == 3));
    endtask

    function automatic vec_t row(input int r, c, a, n, st, l, d);
        vec_t v;
        v.r = r[0];
        v.c = c[0];
        v.a = a[0];
        v.n = n[3:0];
        v.st = st[1:0];
        v.l = l[3:0];
        v.d = d[0];
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        int last;
        int first_dark;
        int relit;
        logic [3:0] prev;
        bus.combat = 1'b0;
        bus.armed = 1'b0;
        bus.cnt_in = 4'd0;

        // Idle heartbeat: LED0 only, toggling every 2 ticks * 4 clk = 8 clk
        step(1, 1, 0, 0);
        check("rst_state", int'(bus.state_out), 0);
        check("rst_leds", int'(bus.leds), 0);
        check("rst_det", int'(bus.detonated), 0);
        prev = bus.leds;
        last = -1;
        for (int i = 0; i < 40; i++) begin
            step(0, 1, 0, 0);
            check("hb_upper", int'(bus.leds[3:1]), 0);
            if (bus.leds != prev) begin
                if (last >= 0) check("hb_period", i - last, 8);
                else check("hb_first", i, 7);
                last = i;
                prev = bus.leds;
            end
        end
        check("hb_seen", int'(last >= 0), 1);

        tbl.push_back(row(1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(row(0, 1, 1, 3, 1, 3, 0));
        tbl.push_back(row(0, 1, 1, 7, 1, 7, 0));
        tbl.push_back(row(0, 1, 0, 1, 1, 1, 0));
        tbl.push_back(row(0, 1, 0, 11, 3, 15, 1));
        tbl.push_back(row(0, 1, 0, 0, 3, 15, 1));
        tbl.push_back(row(0, 0, 0, 11, 0, 0, 0));
        tbl.push_back(row(0, 1, 0, 15, 3, 15, 1));
        tbl.push_back(row(1, 1, 0, 11, 0, 0, 0));
        tbl.push_back(row(0, 1, 0, 11, 3, 15, 1));
        tbl.push_back(row(0, 1, 0, 9, 3, 15, 1));
        tbl.push_back(row(0, 0, 1, 9, 0, 0, 0));
        tbl.push_back(row(0, 1, 1, 9, 2, 9, 0));
        tbl.push_back(row(0, 1, 1, 5, 1, 5, 0));
        tbl.push_back(row(0, 1, 0, 8, 2, 8, 0));
        tbl.push_back(row(0, 1, 0, 0, 0, 1, 0));
        tbl.push_back(row(0, 1, 0, 12, 3, 15, 1));
        tbl.push_back(row(0, 0, 1, 12, 0, 0, 0));
        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].c, tbl[i].a, tbl[i].n);
            check($sformatf("tbl%0d_state", i), int'(bus.state_out), int'(tbl[i].st));
            check($sformatf("tbl%0d_leds", i), int'(bus.leds), int'(tbl[i].l));
            check($sformatf("tbl%0d_det", i), int'(bus.detonated), int'(tbl[i].d));
        end

        // WARN entry on a tick edge: the tick is discarded, so lit exactly 8 clk
        step(0, 1, 1, 3);
        for (int i = 0; i < TD && (m_cyc % TD) != TD - 1; i++) step(0, 1, 1, 3);
        check("align", m_cyc % TD, TD - 1);
        step(0, 1, 1, 9);
        check("warn_entry_state", int'(bus.state_out), 2);
        check("warn_entry_leds", int'(bus.leds), 9);
        first_dark = -1;
        relit = -1;
        for (int i = 1; i <= 24; i++) begin
            step(0, 1, 1, 9);
            check("warn_pattern", int'(bus.leds == 4'd9 || bus.leds == 4'd0), 1);
            if (first_dark < 0 && bus.leds == 4'd0) first_dark = i;
            if (first_dark >= 0 && relit < 0 && bus.leds == 4'd9) relit = i;
        end
        check("warn_first_dark", first_dark, 8);
        check("warn_relit", relit, 16);
        check("warn_dark_now", int'(bus.leds), 0);
        step(0, 1, 1, 5);
        check("warn_exit_state", int'(bus.state_out), 1);
        check("warn_exit_leds", int'(bus.leds), 5);

        // Randomized: inputs held for random stretches so blinking gets exercised
        begin
            logic c, a, r;
            logic [3:0] n;
            c = 1'b1;
            a = 1'b0;
            n = 4'd0;
            for (int i = 0; i < 3000; i++) begin
                r = ($urandom_range(0, 99) == 0);
                if ($urandom_range(0, 7) == 0) begin
                    c = ($urandom_range(0, 7) != 0);
                    a = $urandom_range(0, 1) == 1;
                    n = 4'($urandom_range(0, 15));
                end
                step(r, c, a, n);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/led_status_driver.md
Name: led_status_driver

Overview:
Output stage for the self-destruct path. It consumes the 4-bit countdown value, the 2-of-3 vote flag and the debounced in-combat level, and drives the 4 board LEDs. The LEDs show idle, armed, warning (blinking) and detonated states. It runs on the main 12 MHz clock with an internal prescaler and replaces the plain "11 -> all on" display stage.

Parameters:
TICK_DIV, 120000, main-clock cycles per internal tick (10 ms at 12 MHz); legal range >= 2
BLINK_HALF, 25, ticks per blink half-period (250 ms); legal range >= 1
WARN_LEVEL, 8, count value at which warning blink starts; must be < DEAD_LEVEL
DEAD_LEVEL, 11, count value that means detonated; must be <= 15

Ports:
clk  in  1  main clock (12 MHz)
reset  in  1  synchronous, active-high reset
combat  in  1  debounced in-combat level; 0 forces IDLE and clears detonation
armed  in  1  2-of-3 danger vote (registered upstream)
cnt_in  in  4  countdown value from the self-destruct counter
leds  out  4  LED drive, 1 = lit
detonated  out  1  high while in DEAD
state_out  out  2  IDLE=00, ARMED=01, WARN=10, DEAD=11

Behaviour:
- All state is updated on posedge clk. The reset is synchronous and active-high.
- Reset values:
  - state = IDLE; leds = 0000; detonated = 0; state_out = 00.
  - Prescaler = 0; blink counter = 0; blink_phase = 0.
- Prescaler:
  - Counts 0..TICK_DIV-1, then wraps to 0.
  - tick is a 1-clk pulse on the cycle the prescaler equals TICK_DIV-1.
- Blink counter:
  - Advances on tick only.
  - Counts 0..BLINK_HALF-1; at the wrap it toggles blink_phase.
  - It free-runs in IDLE, ARMED and DEAD.
- Next-state priority (evaluated every clk, highest first):
  1. reset -> IDLE.
  2. combat=0 -> IDLE (this also leaves DEAD).
  3. Current state is DEAD -> stay in DEAD (sticky; cnt_in is ignored).
  4. cnt_in >= DEAD_LEVEL -> DEAD.
  5. cnt_in >= WARN_LEVEL -> WARN.
  6. cnt_in != 0 or armed=1 -> ARMED.
  7. Otherwise -> IDLE.
- WARN entry: on the cycle the FSM enters WARN from any other state, clear the blink counter and set blink_phase=1, so the first half-period is lit. The prescaler is not cleared.
- LED output (registered; computed from the next state and current inputs, so 1-clk latency from an input change to leds):
  - IDLE: leds = {000, combat & blink_phase} (heartbeat on LED0 only while in combat).
  - ARMED: leds = cnt_in.
  - WARN: leds = blink_phase ? cnt_in : 0000.
  - DEAD: leds = 1111.
- detonated = 1 exactly when the registered state is DEAD. state_out mirrors the registered state. Both update in the same cycle as leds.
- Boundaries and corner cases:
  - cnt_in dropping below WARN_LEVEL while in WARN returns to ARMED (or IDLE if cnt_in=0 and armed=0) on the next clk.
  - cnt_in in 12..15 is treated as DEAD.
  - Both combat=0 and cnt_in >= DEAD_LEVEL in the same cycle -> IDLE (combat wins).
  - combat returning to 1 while cnt_in >= DEAD_LEVEL -> DEAD again on the next clk.
  - reset asserted in any state -> reset values on the next edge, independent of the other inputs.
  - tick coinciding with WARN entry -> the entry clear wins.

Test Plan (TICK_DIV=4, BLINK_HALF=2):
- Reset, then combat=1, armed=0, cnt_in=0 -> state_out=00; leds toggles 0000/0001 every 8 clk.
- combat=1, armed=1, cnt_in stepped 1..7 -> state_out=01; leds equals cnt_in one clk after each change; detonated=0.
- cnt_in=9 held -> state_out=10; leds=1001 for the first 8 clk after entry, then 0000 for 8 clk, repeating.
- cnt_in=11 -> next clk state_out=11, leds=1111, detonated=1. Then cnt_in=0 -> stays DEAD. Then combat=0 -> next clk IDLE, leds=0000, detonated=0.
- In DEAD, assert reset for 1 clk with combat=1, cnt_in=11 -> reset values for 1 cycle, then re-enter DEAD on the following clk.
- In WARN, set cnt_in=5 -> next clk state_out=01 and leds=0101, regardless of blink_phase.
